// File: rtl/fir_kernel_pkg.sv
// Shared types and constants for the 4-tap FIR kernel.
// Optional saturation is selected with FIR_KERNEL_SAT_EN (see fir_kernel_mac).
package fir_kernel_pkg;

    localparam int NTAPS    = 4;
    localparam int DW_DEF   = 32;
    localparam int CW_DEF   = 32;
    localparam int CNTW_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } fir_kernel_state_e;

    typedef logic signed [CW_DEF-1:0]          coeff_t;
    typedef logic signed [DW_DEF-1:0]          sample_t;
    typedef logic signed [DW_DEF+CW_DEF+1:0]   acc_t;

endpackage

// File: rtl/fir_kernel_if.sv
// Engine-side kernel handshake plus x/y stream ports of the FIR kernel.
// master = engine driving jobs and samples, slave = the kernel.
interface fir_kernel_if #(
    parameter int DW   = 32,
    parameter int CW   = 32,
    parameter int CNTW = 32
);
    logic                   start_i;
    logic [CNTW-1:0]        n_samples_i;
    logic signed [CW-1:0]   coeff0_i;
    logic signed [CW-1:0]   coeff1_i;
    logic signed [CW-1:0]   coeff2_i;
    logic signed [CW-1:0]   coeff3_i;
    logic signed [DW-1:0]   x_tdata_i;
    logic                   x_tvalid_i;
    logic                   x_tready_o;
    logic signed [DW-1:0]   y_tdata_o;
    logic                   y_tvalid_o;
    logic                   y_tready_i;
    logic                   done_o;
    logic                   idle_o;
    logic                   ready_o;
    logic [CNTW-1:0]        cnt_o;

    modport master (
        output start_i, n_samples_i, coeff0_i, coeff1_i, coeff2_i, coeff3_i,
               x_tdata_i, x_tvalid_i, y_tready_i,
        input  x_tready_o, y_tdata_o, y_tvalid_o, done_o, idle_o, ready_o, cnt_o
    );

    modport slave (
        input  start_i, n_samples_i, coeff0_i, coeff1_i, coeff2_i, coeff3_i,
               x_tdata_i, x_tvalid_i, y_tready_i,
        output x_tready_o, y_tdata_o, y_tvalid_o, done_o, idle_o, ready_o, cnt_o
    );
endinterface

// File: rtl/fir_kernel_mac.sv
// Combinational 4-tap dot product, arithmetic shift and narrowing to DW.
// FIR_KERNEL_SAT_EN selects saturating narrowing; otherwise low DW bits are kept.
module fir_kernel_mac
    import fir_kernel_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CW    = 32,
    parameter int SHIFT = 0
) (
    input  logic signed [CW-1:0] coeff_i [NTAPS],
    input  logic signed [DW-1:0] tap_i   [NTAPS],
    output logic signed [DW-1:0] y_o
);
    localparam int AW = DW + CW + 2;

    logic signed [AW-1:0] sum_s;
    logic signed [AW-1:0] shifted_s;

    // Full-precision sum; operands sign-extended to AW so no product bits are lost
    always_comb begin
        sum_s = '0;
        for (int k = 0; k < NTAPS; k++) begin
            sum_s = sum_s + (AW'(coeff_i[k]) * AW'(tap_i[k]));
        end
        shifted_s = sum_s >>> SHIFT;
    end

`ifdef FIR_KERNEL_SAT_EN
    logic [AW-DW:0] hi_s;
    assign hi_s = shifted_s[AW-1:DW-1];

    // Clamp when the bits above the result sign are not a pure sign extension
    always_comb begin
        if ((&hi_s) || !(|hi_s)) begin
            y_o = shifted_s[DW-1:0];
        end else if (shifted_s[AW-1]) begin
            y_o = {1'b1, {(DW-1){1'b0}}};
        end else begin
            y_o = {1'b0, {(DW-1){1'b1}}};
        end
    end
`else
    assign y_o = DW'(shifted_s);
`endif

endmodule

// File: rtl/fir_kernel_rtl.sv
// 4-tap FIR kernel behind the engine start/done/idle/ready handshake with x/y streams.
// Build option FIR_KERNEL_SAT_EN enables saturating output narrowing.
module fir_kernel_rtl
    import fir_kernel_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int CW    = CW_DEF,
    parameter int SHIFT = 0,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fir_kernel_if.slave   io
);
    fir_kernel_state_e    state_r, next_state_s;
    logic signed [CW-1:0] coeff_r [NTAPS];
    logic signed [DW-1:0] delay_r [NTAPS];
    logic signed [DW-1:0] tap_s   [NTAPS];
    logic [CNTW-1:0]      n_r, in_cnt_r, out_cnt_r;
    logic signed [DW-1:0] y_data_r, mac_y_s;
    logic                 y_valid_r;
    logic                 start_s, x_ready_s, x_acc_s, y_acc_s, last_x_s;

    assign start_s   = (state_r == ST_IDLE) && io.start_i;
    assign x_ready_s = (state_r == ST_RUN) && (!y_valid_r || io.y_tready_i);
    assign x_acc_s   = x_ready_s && io.x_tvalid_i;
    assign y_acc_s   = y_valid_r && io.y_tready_i;
    assign last_x_s  = x_acc_s && (in_cnt_r == (n_r - CNTW'(1'b1)));

    // Taps as they will be after this cycle's shift, so y is registered with the new sample
    always_comb begin
        tap_s[0] = io.x_tdata_i;
        for (int k = 1; k < NTAPS; k++) begin
            tap_s[k] = delay_r[k-1];
        end
    end

    fir_kernel_mac #(
        .DW    (DW),
        .CW    (CW),
        .SHIFT (SHIFT)
    ) u_mac (
        .coeff_i (coeff_r),
        .tap_i   (tap_s),
        .y_o     (mac_y_s)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; FLUSH only ever holds the last sample, so any y accept ends it
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (io.start_i) begin
                    next_state_s = (io.n_samples_i == '0) ? ST_DONE : ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_x_s) begin
                    next_state_s = ST_FLUSH;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (y_acc_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_FLUSH;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Job parameters, delay line, counters and output register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NTAPS; k++) begin
                coeff_r[k] <= '0;
                delay_r[k] <= '0;
            end
            n_r       <= '0;
            in_cnt_r  <= '0;
            out_cnt_r <= '0;
            y_data_r  <= '0;
            y_valid_r <= 1'b0;
        end else if (start_s) begin
            coeff_r[0] <= io.coeff0_i;
            coeff_r[1] <= io.coeff1_i;
            coeff_r[2] <= io.coeff2_i;
            coeff_r[3] <= io.coeff3_i;
            for (int k = 0; k < NTAPS; k++) begin
                delay_r[k] <= '0;
            end
            n_r       <= io.n_samples_i;
            in_cnt_r  <= '0;
            out_cnt_r <= '0;
            y_valid_r <= 1'b0;
        end else begin
            if (x_acc_s) begin
                for (int k = 0; k < NTAPS; k++) begin
                    delay_r[k] <= tap_s[k];
                end
                in_cnt_r  <= in_cnt_r + CNTW'(1'b1);
                y_data_r  <= mac_y_s;
                y_valid_r <= 1'b1;
            end else if (y_acc_s) begin
                y_valid_r <= 1'b0;
            end else begin
                y_valid_r <= y_valid_r;
            end
            if (y_acc_s) begin
                out_cnt_r <= out_cnt_r + CNTW'(1'b1);
            end else begin
                out_cnt_r <= out_cnt_r;
            end
        end
    end

    assign io.x_tready_o = x_ready_s;
    assign io.y_tdata_o  = y_data_r;
    assign io.y_tvalid_o = y_valid_r;
    assign io.done_o     = (state_r == ST_DONE);
    assign io.idle_o     = (state_r == ST_IDLE);
    assign io.ready_o    = last_x_s;
    assign io.cnt_o      = out_cnt_r;

endmodule

// File: tb/tb_fir_kernel_rtl.sv
// Scoreboard bench for fir_kernel_rtl: directed jobs push hand-computed y values,
// a negedge monitor pops and compares on every y handshake and checks y hold under stall.
module tb_fir_kernel_rtl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];

    fir_kernel_if #(.DW(32), .CW(32), .CNTW(32)) bus ();

    fir_kernel_rtl #(.DW(32), .CW(32), .SHIFT(0), .CNTW(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .io    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares every y transfer against the scoreboard and checks stall stability
    initial begin
        logic        prev_stall;
        logic [31:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("y_hold_valid", {63'd0, bus.y_tvalid_o}, 64'd1);
                    check("y_hold_data", {32'd0, bus.y_tdata_o}, {32'd0, prev_data});
                end
                if (bus.y_tvalid_o && bus.y_tready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL y_unexpected: got 0x%0h, expected no transfer", bus.y_tdata_o);
                    end else begin
                        check("y_data", {32'd0, bus.y_tdata_o}, {32'd0, exp_q.pop_front()});
                    end
                end
                prev_stall = bus.y_tvalid_o && !bus.y_tready_i;
                prev_data  = bus.y_tdata_o;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // All tasks start and end at posedge+#1
    task automatic start_job(input logic [31:0] c0, input logic [31:0] c1,
                             input logic [31:0] c2, input logic [31:0] c3,
                             input logic [31:0] n);
        bus.coeff0_i    = c0;
        bus.coeff1_i    = c1;
        bus.coeff2_i    = c2;
        bus.coeff3_i    = c3;
        bus.n_samples_i = n;
        bus.start_i     = 1'b1;
        @(posedge clk); #1;
        bus.start_i     = 1'b0;
    endtask

    task automatic send_x(input logic [31:0] v, input logic last);
        logic acc;
        int   cyc;
        acc = 1'b0;
        cyc = 0;
        bus.x_tdata_i  = v;
        bus.x_tvalid_i = 1'b1;
        while (!acc && cyc < 50) begin
            @(negedge clk);
            acc = bus.x_tready_o;
            if (acc) check("ready_o", {63'd0, bus.ready_o}, {63'd0, last});
            @(posedge clk); #1;
            cyc++;
        end
        if (!acc) check("x_accept_timeout", 64'd0, 64'd1);
        bus.x_tvalid_i = 1'b0;
    endtask

    task automatic wait_done(input logic [31:0] exp_cnt);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = bus.done_o;
        end
        check("done_seen", {63'd0, seen}, 64'd1);
        check("cnt_at_done", {32'd0, bus.cnt_o}, {32'd0, exp_cnt});
        @(posedge clk); #1;
    endtask

    initial begin
        rst            = 1'b1;
        bus.start_i    = 1'b0;
        bus.n_samples_i = 32'd0;
        bus.coeff0_i   = 32'd0;
        bus.coeff1_i   = 32'd0;
        bus.coeff2_i   = 32'd0;
        bus.coeff3_i   = 32'd0;
        bus.x_tdata_i  = 32'd0;
        bus.x_tvalid_i = 1'b0;
        bus.y_tready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_idle", {63'd0, bus.idle_o}, 64'd1);
        check("rst_done", {63'd0, bus.done_o}, 64'd0);
        check("rst_yvalid", {63'd0, bus.y_tvalid_o}, 64'd0);
        check("rst_xready", {63'd0, bus.x_tready_o}, 64'd0);
        check("rst_cnt", {32'd0, bus.cnt_o}, 64'd0);
        @(posedge clk); #1;

        // Impulse response with exact done timing
        start_job(32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
        exp_q.push_back(32'd1); exp_q.push_back(32'd2); exp_q.push_back(32'd3);
        exp_q.push_back(32'd4); exp_q.push_back(32'd0);
        send_x(32'd1, 1'b0);
        send_x(32'd0, 1'b0);
        send_x(32'd0, 1'b0);
        send_x(32'd0, 1'b0);
        send_x(32'd0, 1'b1);
        @(negedge clk);
        check("imp_flush_done", {63'd0, bus.done_o}, 64'd0);
        check("imp_flush_idle", {63'd0, bus.idle_o}, 64'd0);
        @(negedge clk);
        check("imp_done", {63'd0, bus.done_o}, 64'd1);
        check("imp_cnt", {32'd0, bus.cnt_o}, 64'd5);
        @(negedge clk);
        check("imp_done_drop", {63'd0, bus.done_o}, 64'd0);
        check("imp_idle_back", {63'd0, bus.idle_o}, 64'd1);
        check("imp_cnt_hold", {32'd0, bus.cnt_o}, 64'd5);
        @(posedge clk); #1;

        // Backpressure: y#2 stalled for 3 cycles
        start_job(32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
        exp_q.push_back(32'd1); exp_q.push_back(32'd2); exp_q.push_back(32'd3);
        exp_q.push_back(32'd4); exp_q.push_back(32'd0);
        send_x(32'd1, 1'b0);
        send_x(32'd0, 1'b0);
        bus.y_tready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_xready_low", {63'd0, bus.x_tready_o}, 64'd0);
            check("bp_cnt", {32'd0, bus.cnt_o}, 64'd1);
            @(posedge clk); #1;
        end
        bus.y_tready_i = 1'b1;
        send_x(32'd0, 1'b0);
        send_x(32'd0, 1'b0);
        send_x(32'd0, 1'b1);
        wait_done(32'd5);

        // Narrowing of an overflowing sum
        start_job(32'd1, 32'd1, 32'd0, 32'd0, 32'd2);
        exp_q.push_back(32'h7FFF_FFFF);
`ifdef FIR_KERNEL_SAT_EN
        exp_q.push_back(32'h7FFF_FFFF);
`else
        exp_q.push_back(32'hFFFF_FFFE);
`endif
        send_x(32'h7FFF_FFFF, 1'b0);
        send_x(32'h7FFF_FFFF, 1'b1);
        wait_done(32'd2);

        // Zero-length job
        start_job(32'd5, 32'd5, 32'd5, 32'd5, 32'd0);
        @(negedge clk);
        check("zero_done", {63'd0, bus.done_o}, 64'd1);
        check("zero_xready", {63'd0, bus.x_tready_o}, 64'd0);
        check("zero_cnt", {32'd0, bus.cnt_o}, 64'd0);
        @(negedge clk);
        check("zero_done_drop", {63'd0, bus.done_o}, 64'd0);
        check("zero_idle", {63'd0, bus.idle_o}, 64'd1);
        @(posedge clk); #1;

        // Reset in the middle of an 8-sample job
        start_job(32'd1, 32'd2, 32'd3, 32'd4, 32'd8);
        exp_q.push_back(32'd5); exp_q.push_back(32'd16);
        send_x(32'd5, 1'b0);
        send_x(32'd6, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rst_idle", {63'd0, bus.idle_o}, 64'd1);
        check("mid_rst_yvalid", {63'd0, bus.y_tvalid_o}, 64'd0);
        check("mid_rst_cnt", {32'd0, bus.cnt_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        start_job(32'd1, 32'd1, 32'd1, 32'd1, 32'd3);
        exp_q.push_back(32'd1); exp_q.push_back(32'd3); exp_q.push_back(32'd6);
        send_x(32'd1, 1'b0);
        send_x(32'd2, 1'b0);
        send_x(32'd3, 1'b1);
        wait_done(32'd3);

        // Start ignored during RUN, then back-to-back job with fresh taps
        start_job(32'd2, 32'd0, 32'd0, 32'd0, 32'd3);
        exp_q.push_back(32'd2); exp_q.push_back(32'd4); exp_q.push_back(32'd6);
        send_x(32'd1, 1'b0);
        bus.coeff0_i    = 32'd9;
        bus.coeff1_i    = 32'd9;
        bus.n_samples_i = 32'd1;
        bus.start_i     = 1'b1;
        @(negedge clk);
        check("b2b_run_idle", {63'd0, bus.idle_o}, 64'd0);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        send_x(32'd2, 1'b0);
        send_x(32'd3, 1'b1);
        wait_done(32'd3);
        start_job(32'd0, 32'd1, 32'd0, 32'd0, 32'd2);
        exp_q.push_back(32'd0); exp_q.push_back(32'd7);
        send_x(32'd7, 1'b0);
        send_x(32'd8, 1'b1);
        wait_done(32'd2);

        repeat (2) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
